ber_checker: RTL
================

Name: ber_checker

Overview:
- Parametrised BER checker for the receive path.
- Aligns the received bit stream i_rx against the locally generated reference stream i_ref by scanning every candidate latency, then locks on the best one and accumulates bit and error counts.
- Over the previous-generation counter it adds: parametrised depth, window and count widths; a buffer-fill phase; lock-loss detection with automatic resync; external resync and counter-clear controls; and saturating counters.
- It sits after the slicer/decision stage, next to the PRBS reference generator.

Parameters:
- NB_COUNT, 64, width of o_errors and o_bits.
- BUF_DEPTH, 512, number of candidate latencies, 0..BUF_DEPTH-1 (power of two, >=4).
- SYNC_LEN, 511, valid samples accumulated per candidate latency.
- LOCK_WIN, 1024, valid samples per lock-monitor window.
- RESYNC_THR, 64, errors within one lock window that declare lock lost.

Ports:
- clock, in, 1, system clock; all logic on the rising edge.
- i_reset, in, 1, asynchronous, active-high reset.
- i_valid, in, 1, qualifies i_rx/i_ref; nothing advances when low.
- i_rx, in, 1, received bit.
- i_ref, in, 1, reference bit.
- i_resync, in, 1, single-cycle request to restart latency scan.
- i_clear, in, 1, single-cycle request to zero o_errors/o_bits.
- o_errors, out, NB_COUNT, accumulated errors while locked.
- o_bits, out, NB_COUNT, accumulated compared bits while locked.
- o_synced, out, 1, high in LOCKED state.
- o_latency, out, clog2(BUF_DEPTH), locked latency; 0 when not synced.
- o_lock_loss, out, 8, saturating count of automatic resyncs.

Behaviour:
- Reset (async, i_reset=1):
  - state=FILL; reference buffer all zeros.
  - All counters 0; best_err = SYNC_LEN; best_lat = 0.
  - All outputs 0.
- Reference buffer:
  - Shifts in i_ref on each valid sample.
  - tap[k] = the i_ref value k valid samples earlier; tap[0] = current i_ref (combinational).
  - Depth is BUF_DEPTH-1 registers.
- FILL:
  - Counts valid samples.
  - After BUF_DEPTH-1 valid samples, go to SCAN with cand=0, err_acc=0, smp=0.
  - No comparisons are made in FILL.
- SCAN, per valid sample:
  - err_acc += tap[cand] ^ i_rx; smp += 1.
  - On the sample where smp==SYNC_LEN-1, form final = err_acc + current error.
  - If final < best_err (strict): best_err<=final, best_lat<=cand. Ties keep the lower latency.
  - Then err_acc<=0, smp<=0, cand<=cand+1.
  - After the window for cand=BUF_DEPTH-1 closes, go to LOCKED with lat = best_lat, including the last window's result.
- LOCKED, per valid sample:
  - bit_count += 1; error_count += tap[lat] ^ i_rx.
  - Both counters saturate at all-ones and never wrap.
  - Window monitor: win_smp and win_err count per LOCK_WIN samples.
  - If win_err reaches RESYNC_THR (including the current sample): go to SCAN next cycle, o_lock_loss += 1 (saturating at 255), scan variables reinitialised. Buffer stays filled, so no FILL.
  - At the end of a window without reaching the threshold, win_smp and win_err reset to 0.
  - Counters hold while not LOCKED.
- i_resync, any state:
  - Next state is SCAN, or FILL if currently in FILL (fill continues uninterrupted).
  - cand, err_acc, smp, best_err=SYNC_LEN and best_lat are reinitialised.
  - o_lock_loss is not incremented; error/bit counters are untouched.
  - The sample presented in the same cycle is discarded.
- i_clear:
  - Next cycle error_count=bit_count=0.
  - A simultaneous valid LOCKED sample is not counted; clear wins.
  - Does not affect the state machine or o_lock_loss.
- Priority: i_reset > i_resync > auto lock-loss > normal update; i_clear is independent.
- Outputs are registered; updates appear the cycle after the qualifying valid sample.
- i_valid low: all state and counters hold, including mid-window.
- Lock time from reset (defaults): 511 + 512*511 valid samples.

Test Plan (BUF_DEPTH=8, SYNC_LEN=16, LOCK_WIN=32, RESYNC_THR=4, PRBS9 ref, i_valid=1):
- rx = ref delayed by 5 valid samples -> o_synced rises after the 135th valid sample, o_latency=5; 1000 further samples give o_bits=1000, o_errors=0.
- Same alignment with every 100th rx bit inverted (3 flips within any 32-sample window never occurs) -> o_errors=10 after 1000 locked bits; o_lock_loss=0.
- While locked, switch delay 5->2 -> lock lost within 32 samples, o_lock_loss=1, o_synced=0; relock with o_latency=2 after 128 more samples.
- i_valid toggled 50% random during the first case -> same o_latency=5; lock reached after exactly 135 valid samples; counters unchanged on invalid cycles.
- i_clear in the same cycle as a valid erroneous locked sample -> o_errors=0, o_bits=0 next cycle. i_resync while LOCKED -> o_synced=0 next cycle, o_lock_loss unchanged, counters held.
- Async i_reset asserted mid-SCAN between clock edges -> outputs 0 immediately; restart requires full FILL + SCAN. Counter saturation check with NB_COUNT=4 -> o_bits sticks at 15.

Source files
------------

// File: rtl/ber_checker.sv
// Receive-path BER checker: scans every candidate latency of the reference stream against i_rx,
// locks on the best one, then accumulates saturating bit/error counts with lock-loss resync.
module ber_checker #(
    parameter int NB_COUNT   = 64,
    parameter int BUF_DEPTH  = 512,
    parameter int SYNC_LEN   = 511,
    parameter int LOCK_WIN   = 1024,
    parameter int RESYNC_THR = 64,
    localparam int LAT_W     = $clog2(BUF_DEPTH)
) (
    input  logic                clock,
    input  logic                i_reset,
    input  logic                i_valid,
    input  logic                i_rx,
    input  logic                i_ref,
    input  logic                i_resync,
    input  logic                i_clear,
    output logic [NB_COUNT-1:0] o_errors,
    output logic [NB_COUNT-1:0] o_bits,
    output logic                o_synced,
    output logic [LAT_W-1:0]    o_latency,
    output logic [7:0]          o_lock_loss
);
    localparam int ACC_W  = $clog2(SYNC_LEN + 1);
    localparam int WIN_W  = $clog2(LOCK_WIN);
    localparam int WERR_W = $clog2(RESYNC_THR + 1);

    typedef enum logic [1:0] {FILL, SCAN, LOCKED} state_t;

    state_t               state, state_next;
    logic [BUF_DEPTH-2:0] ref_buf;
    logic [BUF_DEPTH-1:0] taps;
    logic [LAT_W-1:0]     fill_cnt, cand, best_lat, lat;
    logic [ACC_W-1:0]     err_acc, smp, best_err, scan_final;
    logic [WIN_W-1:0]     win_smp;
    logic [WERR_W-1:0]    win_err, win_err_total;
    logic [NB_COUNT-1:0]  err_count, bit_count;
    logic [7:0]           lock_loss;
    logic                 scan_err, lock_err, scan_last, last_cand, better, loss;
    logic                 scan_init, auto_loss, locked_upd;

    // tap[0] is the live reference bit; tap[k] is k valid samples old
    assign taps          = {ref_buf, i_ref};
    assign scan_err      = taps[cand] ^ i_rx;
    assign lock_err      = taps[lat] ^ i_rx;
    assign scan_final    = err_acc + ACC_W'(scan_err);
    assign scan_last     = (smp == ACC_W'(SYNC_LEN - 1));
    assign last_cand     = (cand == LAT_W'(BUF_DEPTH - 1));
    assign better        = (scan_final < best_err);
    assign win_err_total = win_err + WERR_W'(lock_err);
    assign loss          = (win_err_total >= WERR_W'(RESYNC_THR));
    assign locked_upd    = (state == LOCKED) && i_valid && !i_resync;

    always_comb begin
        state_next = state;
        scan_init  = 1'b0;
        auto_loss  = 1'b0;
        unique case (state)
            FILL: begin
                if (i_valid && fill_cnt == LAT_W'(BUF_DEPTH - 2)) begin
                    state_next = SCAN;
                    scan_init  = 1'b1;
                end
            end
            SCAN: begin
                if (i_valid && scan_last && last_cand) state_next = LOCKED;
            end
            LOCKED: begin
                if (i_valid && loss) begin
                    state_next = SCAN;
                    scan_init  = 1'b1;
                    auto_loss  = 1'b1;
                end
            end
            default: state_next = FILL;
        endcase
        // An external resync overrides everything; a fill in progress keeps filling
        if (i_resync) begin
            state_next = (state == FILL) ? FILL : SCAN;
            scan_init  = 1'b1;
            auto_loss  = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) state <= FILL;
        else         state <= state_next;
    end

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            ref_buf   <= '0;
            fill_cnt  <= '0;
            cand      <= '0;
            err_acc   <= '0;
            smp       <= '0;
            best_err  <= ACC_W'(SYNC_LEN);
            best_lat  <= '0;
            lat       <= '0;
            win_smp   <= '0;
            win_err   <= '0;
            err_count <= '0;
            bit_count <= '0;
            lock_loss <= '0;
        end else begin
            if (i_valid) ref_buf <= {ref_buf[BUF_DEPTH-3:0], i_ref};
            if (state == FILL && i_valid) fill_cnt <= fill_cnt + 1'b1;

            if (scan_init) begin
                cand     <= '0;
                err_acc  <= '0;
                smp      <= '0;
                best_err <= ACC_W'(SYNC_LEN);
                best_lat <= '0;
            end else if (state == SCAN && i_valid) begin
                if (scan_last) begin
                    if (better) begin
                        best_err <= scan_final;
                        best_lat <= cand;
                    end
                    if (last_cand) lat <= better ? cand : best_lat;
                    err_acc <= '0;
                    smp     <= '0;
                    cand    <= cand + 1'b1;
                end else begin
                    err_acc <= scan_final;
                    smp     <= smp + 1'b1;
                end
            end

            if (state != LOCKED) begin
                win_smp <= '0;
                win_err <= '0;
            end else if (locked_upd) begin
                if (loss || win_smp == WIN_W'(LOCK_WIN - 1)) begin
                    win_smp <= '0;
                    win_err <= '0;
                end else begin
                    win_smp <= win_smp + 1'b1;
                    win_err <= win_err_total;
                end
            end

            // Clear takes precedence over a coincident locked sample
            if (i_clear) begin
                err_count <= '0;
                bit_count <= '0;
            end else if (locked_upd) begin
                if (bit_count != '1) bit_count <= bit_count + 1'b1;
                if (lock_err && err_count != '1) err_count <= err_count + 1'b1;
            end

            if (auto_loss && lock_loss != 8'hFF) lock_loss <= lock_loss + 1'b1;
        end
    end

    assign o_synced    = (state == LOCKED);
    assign o_latency   = o_synced ? lat : '0;
    assign o_errors    = err_count;
    assign o_bits      = bit_count;
    assign o_lock_loss = lock_loss;
endmodule
